// File: rtl/ppu_frame_writer.sv
// rtl/ppu_frame_writer.sv - PPU pixel stream to double-buffered 2bpp framebuffer writer
module ppu_frame_writer #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int FIFO_DEPTH = 4,
    parameter int FB_AW      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PX_OUT,
    input  logic             PX_valid,
    input  logic [1:0]       PPU_MODE,
    input  logic [7:0]       BGP,
    input  logic             LCD_EN,
    output logic [FB_AW-1:0] FB_ADDR,
    output logic [7:0]       FB_DATA,
    output logic             FB_WE,
    input  logic             FB_READY,
    output logic             DISP_BUF,
    output logic             FRAME_DONE,
    output logic             OVERFLOW
);

    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam int OW = FB_AW - 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] X_MAX = XW'(H_PIXELS);
    localparam logic [YW-1:0] Y_MAX = YW'(V_LINES);
    localparam logic [PW:0]   F_MAX = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] M_HBLANK = 2'd0;
    localparam logic [1:0] M_VBLANK = 2'd1;
    localparam logic [1:0] M_SCAN   = 2'd2;
    localparam logic [1:0] M_DRAW   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        SWAP   = 2'd3
    } state_t;

    state_t state, state_n;

    logic [1:0]    prev_mode;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [5:0]    pack;
    logic [1:0]    pack_cnt;
    logic          wr_buf;
    logic          disp_buf;
    logic          overflow;

    logic             stg_vld;
    logic [FB_AW-1:0] stg_addr;
    logic [7:0]       stg_data;

    logic [FB_AW-1:0] mem_addr [FIFO_DEPTH];
    logic [7:0]       mem_data [FIFO_DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic [PW:0]      count;

    logic [1:0]       shade;
    logic [OW-1:0]    y_ext, y40, offset;
    logic [FB_AW-1:0] push_addr;
    logic [7:0]       flush_byte;
    logic             mode_eol, mode_vb;

    logic       accept, push, line_end, y_inc, do_swap;
    logic [7:0] push_data;

    logic fifo_empty, fifo_full, pop, fifo_wr;

    assign shade      = BGP[{PX_OUT, 1'b0} +: 2];
    assign y_ext      = OW'(y);
    assign y40        = (y_ext << 5) + (y_ext << 3);
    assign offset     = y40 + OW'(x >> 2);
    assign push_addr  = {wr_buf, offset};
    assign mode_eol   = (prev_mode == M_DRAW) && (PPU_MODE == M_HBLANK);
    assign mode_vb    = (prev_mode != M_VBLANK) && (PPU_MODE == M_VBLANK);

    // Partial bytes keep their pixels left-aligned; unused low slots are zero.
    always_comb begin
        flush_byte = 8'h00;
        case (pack_cnt)
            2'd1:    flush_byte = {pack[1:0], 6'b0};
            2'd2:    flush_byte = {pack[3:0], 4'b0};
            2'd3:    flush_byte = {pack[5:0], 2'b0};
            default: flush_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        push      = 1'b0;
        push_data = 8'h00;
        line_end  = 1'b0;
        y_inc     = 1'b0;
        do_swap   = 1'b0;
        case (state)
            IDLE: begin
                if (PPU_MODE == M_SCAN && y == '0)
                    state_n = ACTIVE;
            end
            ACTIVE: begin
                if (mode_vb) begin
                    push      = (pack_cnt != 2'd0);
                    push_data = flush_byte;
                    line_end  = 1'b1;
                    state_n   = DRAIN;
                end else if (mode_eol) begin
                    push      = (pack_cnt != 2'd0);
                    push_data = flush_byte;
                    line_end  = 1'b1;
                    y_inc     = 1'b1;
                end else if (PX_valid && x < X_MAX && y < Y_MAX) begin
                    accept    = 1'b1;
                    push      = (pack_cnt == 2'd3);
                    push_data = {pack, shade};
                end
            end
            DRAIN: begin
                if (!stg_vld && fifo_empty)
                    state_n = SWAP;
            end
            SWAP: begin
                do_swap = 1'b1;
                state_n = ACTIVE;
            end
            default: state_n = IDLE;
        endcase
        // Display disable wins over everything, including a pending swap.
        if (!LCD_EN) begin
            state_n  = IDLE;
            accept   = 1'b0;
            push     = 1'b0;
            line_end = 1'b0;
            y_inc    = 1'b0;
            do_swap  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev_mode <= M_HBLANK;
        end else begin
            state     <= state_n;
            prev_mode <= PPU_MODE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            pack     <= '0;
            pack_cnt <= '0;
        end else if (!LCD_EN || state == IDLE) begin
            x        <= '0;
            y        <= '0;
            pack     <= '0;
            pack_cnt <= '0;
        end else if (do_swap) begin
            x        <= '0;
            y        <= '0;
            pack     <= '0;
            pack_cnt <= '0;
        end else if (line_end) begin
            x        <= '0;
            pack     <= '0;
            pack_cnt <= '0;
            if (y_inc && y != Y_MAX)
                y <= y + YW'(1);
        end else if (accept) begin
            pack     <= {pack[3:0], shade};
            pack_cnt <= pack_cnt + 2'd1;
            x        <= x + XW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf   <= 1'b0;
            disp_buf <= 1'b1;
        end else if (do_swap) begin
            disp_buf <= wr_buf;
            wr_buf   <= ~wr_buf;
        end
    end

    // One register stage between packing and the FIFO keeps the address adder off the FIFO write path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld  <= 1'b0;
            stg_addr <= '0;
            stg_data <= '0;
        end else begin
            stg_vld <= push;
            if (push) begin
                stg_addr <= push_addr;
                stg_data <= push_data;
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == F_MAX);
    assign pop        = !fifo_empty && FB_READY;
    assign fifo_wr    = stg_vld && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem_addr[wptr] <= stg_addr;
                mem_data[wptr] <= stg_data;
                wptr           <= wptr + PW'(1);
            end
            if (pop)
                rptr <= rptr + PW'(1);
            if (fifo_wr && !pop)
                count <= count + (PW+1)'(1);
            else if (!fifo_wr && pop)
                count <= count - (PW+1)'(1);
            if (stg_vld && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    assign FB_WE      = !fifo_empty;
    assign FB_ADDR    = mem_addr[rptr];
    assign FB_DATA    = mem_data[rptr];
    assign DISP_BUF   = disp_buf;
    assign FRAME_DONE = do_swap;
    assign OVERFLOW   = overflow;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// tb/tb_ppu_frame_writer.sv - directed self-checking bench for ppu_frame_writer
module tb_ppu_frame_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PX_OUT;
    logic        PX_valid;
    logic [1:0]  PPU_MODE;
    logic [7:0]  BGP;
    logic        LCD_EN;
    logic [13:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        FB_WE;
    logic        FB_READY;
    logic        DISP_BUF;
    logic        FRAME_DONE;
    logic        OVERFLOW;

    int n_pass = 0;
    int n_total = 0;

    logic [13:0] mon_addr [$];
    logic [7:0]  mon_data [$];
    int          fd_n = 0;
    int          fd_wr_at = 0;

    ppu_frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .PX_OUT     (PX_OUT),
        .PX_valid   (PX_valid),
        .PPU_MODE   (PPU_MODE),
        .BGP        (BGP),
        .LCD_EN     (LCD_EN),
        .FB_ADDR    (FB_ADDR),
        .FB_DATA    (FB_DATA),
        .FB_WE      (FB_WE),
        .FB_READY   (FB_READY),
        .DISP_BUF   (DISP_BUF),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (FB_WE && FB_READY) begin
                mon_addr.push_back(FB_ADDR);
                mon_data.push_back(FB_DATA);
            end
            if (FRAME_DONE) begin
                fd_n     <= fd_n + 1;
                fd_wr_at <= mon_addr.size();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic px(input logic [1:0] idx);
        PX_OUT   = idx;
        PX_valid = 1'b1;
        cyc();
        PX_valid = 1'b0;
    endtask

    task automatic mode(input logic [1:0] m);
        PPU_MODE = m;
        cyc();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        PX_valid = 1'b0;
        PX_OUT   = 2'd0;
        FB_READY = 1'b1;
        LCD_EN   = 1'b1;
        PPU_MODE = 2'd0;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; PX_valid = 1'b0; PX_OUT = 2'd0; PPU_MODE = 2'd0;
        BGP = 8'h00; LCD_EN = 1'b0; FB_READY = 1'b1;
        #2;
        n_total++;
        if ({FB_WE, FB_ADDR, FB_DATA, DISP_BUF, FRAME_DONE, OVERFLOW} !== {1'b0, 14'h0, 8'h00, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset: we=%b addr=%h data=%h disp=%b fd=%b ovf=%b required 0 0000 00 1 0 0",
                     FB_WE, FB_ADDR, FB_DATA, DISP_BUF, FRAME_DONE, OVERFLOW);
        else n_pass++;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_first_byte();
        do_reset();
        BGP = 8'hE4;
        mode(2'd2);
        mode(2'd3);
        px(2'd3); px(2'd2); px(2'd1); px(2'd0);
        n_total++;
        if (FB_WE !== 1'b0) $display("FAIL first_latency1: we=%b required 0", FB_WE);
        else n_pass++;
        cyc();
        n_total++;
        if ({FB_WE, FB_ADDR, FB_DATA} !== {1'b1, 14'h0000, 8'hE4})
            $display("FAIL first_byte: we=%b addr=%h data=%h required 1 0000 e4", FB_WE, FB_ADDR, FB_DATA);
        else n_pass++;
    endtask

    task automatic test_full_line();
        int base;
        int bad;
        do_reset();
        BGP = 8'h1B;
        base = mon_addr.size();
        mode(2'd2);
        mode(2'd3);
        for (int i = 0; i < 162; i++) px(2'd0);
        mode(2'd0);
        idle(6);
        n_total++;
        if (mon_addr.size() - base !== 40)
            $display("FAIL line_count: got %0d writes required 40", mon_addr.size() - base);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 40 && base + i < mon_addr.size(); i++)
            if (mon_addr[base+i] !== 14'(i) || mon_data[base+i] !== 8'hFF) bad++;
        n_total++;
        if (bad != 0) $display("FAIL line_content: %0d bad writes required 0 (addr i, data ff)", bad);
        else n_pass++;
    endtask

    task automatic test_partial_line();
        int base;
        BGP = 8'hE4;
        base = mon_addr.size();
        mode(2'd2);
        mode(2'd3);
        for (int i = 0; i < 6; i++) px(2'd3);
        mode(2'd0);
        mode(2'd2);
        mode(2'd3);
        for (int i = 0; i < 4; i++) px(2'd3);
        idle(4);
        n_total++;
        if (mon_addr.size() - base !== 3) $display("FAIL partial_count: got %0d required 3", mon_addr.size() - base);
        else n_pass++;
        if (mon_addr.size() - base == 3) begin
            n_total++;
            if ({mon_addr[base], mon_data[base]} !== {14'h0028, 8'hFF})
                $display("FAIL partial_w0: %h/%h required 0028/ff", mon_addr[base], mon_data[base]);
            else n_pass++;
            n_total++;
            if ({mon_addr[base+1], mon_data[base+1]} !== {14'h0029, 8'hF0})
                $display("FAIL partial_pad: %h/%h required 0029/f0", mon_addr[base+1], mon_data[base+1]);
            else n_pass++;
            n_total++;
            if ({mon_addr[base+2], mon_data[base+2]} !== {14'h0050, 8'hFF})
                $display("FAIL next_line: %h/%h required 0050/ff", mon_addr[base+2], mon_data[base+2]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int base;
        int unstable;
        logic [13:0] ea [5];
        logic [7:0]  ed [5];
        ea[0] = 14'd0; ea[1] = 14'd1; ea[2] = 14'd2; ea[3] = 14'd3; ea[4] = 14'd5;
        ed[0] = 8'h55; ed[1] = 8'hAA; ed[2] = 8'hFF; ed[3] = 8'h00; ed[4] = 8'hAA;
        do_reset();
        BGP = 8'hE4;
        base = mon_addr.size();
        mode(2'd2);
        mode(2'd3);
        FB_READY = 1'b0;
        unstable = 0;
        for (int k = 0; k < 5; k++)
            for (int p = 0; p < 4; p++) begin
                px(2'((k + 1) % 4));
                if (FB_WE && (FB_ADDR !== 14'h0 || FB_DATA !== 8'h55)) unstable++;
            end
        n_total++;
        if (OVERFLOW !== 1'b0) $display("FAIL ovf_early: ovf=%b required 0", OVERFLOW);
        else n_pass++;
        cyc();
        n_total++;
        if (OVERFLOW !== 1'b1) $display("FAIL ovf_set: ovf=%b required 1", OVERFLOW);
        else n_pass++;
        cyc();
        if (FB_ADDR !== 14'h0 || FB_DATA !== 8'h55) unstable++;
        n_total++;
        if (unstable != 0) $display("FAIL hold_stable: %0d unstable samples required 0", unstable);
        else n_pass++;
        FB_READY = 1'b1;
        for (int p = 0; p < 4; p++) px(2'd2);
        mode(2'd0);
        idle(8);
        n_total++;
        if (mon_addr.size() - base !== 5) $display("FAIL bp_count: got %0d required 5", mon_addr.size() - base);
        else n_pass++;
        if (mon_addr.size() - base == 5)
            for (int i = 0; i < 5; i++) begin
                n_total++;
                if ({mon_addr[base+i], mon_data[base+i]} !== {ea[i], ed[i]})
                    $display("FAIL bp_order%0d: %h/%h required %h/%h", i, mon_addr[base+i], mon_data[base+i], ea[i], ed[i]);
                else n_pass++;
            end
        n_total++;
        if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky: ovf=%b required 1", OVERFLOW);
        else n_pass++;
    endtask

    task automatic test_frame_swap();
        int base;
        int fd0;
        int bad;
        int waited;
        do_reset();
        BGP = 8'hE4;
        base = mon_addr.size();
        fd0 = fd_n;
        for (int l = 0; l < 144; l++) begin
            mode(2'd2);
            mode(2'd3);
            for (int i = 0; i < 160; i++) px(2'(i % 4));
            mode(2'd0);
        end
        idle(4);
        n_total++;
        if (DISP_BUF !== 1'b1) $display("FAIL disp_before: %b required 1", DISP_BUF);
        else n_pass++;
        PPU_MODE = 2'd1;
        waited = 0;
        while (FRAME_DONE !== 1'b1 && waited < 20) begin
            cyc();
            waited++;
        end
        n_total++;
        if (FRAME_DONE !== 1'b1) $display("FAIL frame_done_timeout: fd=%b after %0d cycles required 1", FRAME_DONE, waited);
        else n_pass++;
        idle(6);
        n_total++;
        if (DISP_BUF !== 1'b0) $display("FAIL disp_after: %b required 0", DISP_BUF);
        else n_pass++;
        n_total++;
        if (fd_n - fd0 !== 1) $display("FAIL fd_pulses: %0d required 1", fd_n - fd0);
        else n_pass++;
        n_total++;
        if (mon_addr.size() - base !== 5760) $display("FAIL frame_count: %0d required 5760", mon_addr.size() - base);
        else n_pass++;
        n_total++;
        if (fd_wr_at - base !== 5760) $display("FAIL fd_after_last: writes at pulse %0d required 5760", fd_wr_at - base);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5760 && base + i < mon_addr.size(); i++)
            if (mon_addr[base+i] !== 14'(i) || mon_data[base+i] !== 8'h1B) bad++;
        n_total++;
        if (bad != 0) $display("FAIL frame_content: %0d bad writes required 0", bad);
        else n_pass++;
        base = mon_addr.size();
        mode(2'd2);
        mode(2'd3);
        for (int i = 0; i < 4; i++) px(2'd3);
        idle(4);
        n_total++;
        if (mon_addr.size() - base !== 1 || mon_addr[mon_addr.size()-1] !== 14'h2000 || mon_data[mon_data.size()-1] !== 8'hFF)
            $display("FAIL second_buf: n=%0d last=%h/%h required 1 2000/ff",
                     mon_addr.size() - base, mon_addr[mon_addr.size()-1], mon_data[mon_data.size()-1]);
        else n_pass++;
    endtask

    task automatic test_lcd_off();
        int base;
        int fd0;
        do_reset();
        BGP = 8'hE4;
        base = mon_addr.size();
        fd0 = fd_n;
        mode(2'd2);
        mode(2'd3);
        for (int i = 0; i < 82; i++) px(2'd1);
        LCD_EN = 1'b0;
        for (int i = 0; i < 6; i++) px(2'd1);
        mode(2'd0);
        mode(2'd1);
        idle(10);
        n_total++;
        if (mon_addr.size() - base !== 20) $display("FAIL off_count: %0d required 20", mon_addr.size() - base);
        else n_pass++;
        n_total++;
        if (fd_n != fd0 || DISP_BUF !== 1'b1) $display("FAIL off_noswap: pulses=%0d disp=%b required 0 1", fd_n - fd0, DISP_BUF);
        else n_pass++;
        base = mon_addr.size();
        LCD_EN = 1'b1;
        mode(2'd2);
        mode(2'd3);
        for (int i = 0; i < 4; i++) px(2'd2);
        idle(4);
        n_total++;
        if (mon_addr.size() - base !== 1 || mon_addr[mon_addr.size()-1] !== 14'h0000 || mon_data[mon_data.size()-1] !== 8'hAA)
            $display("FAIL reenable: n=%0d last=%h/%h required 1 0000/aa",
                     mon_addr.size() - base, mon_addr[mon_addr.size()-1], mon_data[mon_data.size()-1]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_byte();
        test_full_line();
        test_partial_line();
        test_backpressure();
        test_frame_swap();
        test_lcd_off();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ppu_frame_writer.md
Name: ppu_frame_writer

Overview:
- Downstream consumer of the PPU pixel stream (`PX_OUT`/`PX_valid`).
- Maps each 2-bit colour index through `BGP` and packs 4 shades per byte.
- Writes each byte into one half of a double-buffered 2bpp framebuffer RAM through a small write FIFO.
- Swaps buffers at V-blank so the display scan-out side always reads a complete frame.

Parameters:
- `H_PIXELS`, 160, visible pixels per line.
- `V_LINES`, 144, visible lines per frame.
- `FIFO_DEPTH`, 4, write-FIFO entries (power of two, ≥2).
- `FB_AW`, 14, framebuffer address width. Bit 13 is the buffer select; bits 12:0 are the byte offset, max 5759.

Ports:
- `clk` in 1: system clock, same as PPU.
- `rst` in 1: asynchronous, active-high reset.
- `PX_OUT` in 2: pixel colour index from PPU.
- `PX_valid` in 1: `PX_OUT` valid this cycle.
- `PPU_MODE` in 2: 0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW.
- `BGP` in 8: palette register FF47.
- `LCD_EN` in 1: LCDC[7].
- `FB_ADDR` out `FB_AW`: framebuffer write address.
- `FB_DATA` out 8: packed pixels, first pixel in [7:6], fourth in [1:0].
- `FB_WE` out 1: write request.
- `FB_READY` in 1: RAM accepts the write this cycle.
- `DISP_BUF` out 1: buffer select the display reads.
- `FRAME_DONE` out 1: one-cycle pulse on buffer swap.
- `OVERFLOW` out 1: sticky, FIFO was full when a byte had to be pushed.

Behaviour:
- Reset (async) values:
  - `FB_WE`=0, `FB_ADDR`=0, `FB_DATA`=0, `DISP_BUF`=1, `FRAME_DONE`=0, `OVERFLOW`=0.
  - Internal: write buffer=0, x=0, y=0, pack count=0, FIFO empty, state=IDLE.
- Pixel accept:
  - Condition: `PX_valid`=1, state=ACTIVE, x<`H_PIXELS`, y<`V_LINES`.
  - shade = `BGP`[2*`PX_OUT`+1 : 2*`PX_OUT`], sampled in the accept cycle.
  - The shade is shifted into the pack register; x increments.
  - Pixels failing the condition are dropped with no counter change, including the extra pixels at x≥160.
- Byte push:
  - When the 4th pixel is accepted, push {addr, byte} to the FIFO in the same cycle.
  - addr = {write buffer, y*40 + (x_before_accept>>2)}; byte is registered into the FIFO next edge.
  - Arithmetic is 13-bit unsigned; y*40 is computed as (y<<5)+(y<<3).
- End of line:
  - Trigger: `PPU_MODE` 3 then 0, detected by registering the previous mode.
  - If 1–3 pixels are packed, pad the unused low positions with 00 and push.
  - Then x←0, y←y+1 (saturating at `V_LINES`).
- FIFO:
  - `FB_WE`=!empty; `FB_ADDR`/`FB_DATA` come from the head entry and are stable while `FB_WE`=1 and `FB_READY`=0.
  - Pop on `FB_WE`&&`FB_READY`.
  - Push and pop in the same cycle when full is legal: count unchanged.
  - Push while full and no pop: byte dropped, `OVERFLOW`←1 (cleared only by `rst`).
- State machine:
  - IDLE: entered when `LCD_EN`=0. x, y and the pack register are cleared and the partial byte is discarded; the FIFO keeps draining. Exit to ACTIVE when `LCD_EN`=1 and `PPU_MODE`=2 and y=0.
  - ACTIVE → DRAIN: on the `PPU_MODE` transition into 1. Any partial byte is flushed first, with the same padding rule.
  - DRAIN → SWAP: when the FIFO is empty. Pixels arriving in DRAIN are dropped.
  - SWAP (1 cycle): `DISP_BUF`←write buffer, write buffer←~write buffer, `FRAME_DONE`=1, y←0, x←0 → ACTIVE.
  - `LCD_EN`=0 in any state → IDLE next cycle, overriding all other transitions. No swap and no `FRAME_DONE`.
- Latency: 4th pixel accept → `FB_WE` high 2 cycles later if the FIFO was empty.

Test Plan:
- Reset, `BGP`=0xE4, `LCD_EN`=1, mode 2→3, stream indices 3,2,1,0 at y=0 → `FB_WE` with `FB_ADDR`=0x0000, `FB_DATA`=0xE4, 2 cycles after the 4th pixel.
- `BGP`=0x1B, stream 160 pixels of index 0 then 2 extra valid pixels, mode 3→0 → exactly 40 writes with data 0xFF, addrs 0x0000–0x0027; extras dropped.
- Line 1 with 6 pixels of index 3 then mode 3→0 (`BGP`=0xE4) → writes 0xFF @0x0028 and 0xF0 @0x0029; next line starts at 0x0050.
- Hold `FB_READY`=0 for 20 cycles during streaming → `FB_ADDR`/`FB_DATA` stable while waiting, `OVERFLOW`=1 after the 5th unaccepted byte, later writes resume in order.
- Full frame then mode→1 → `FRAME_DONE` pulses once after the last write, `DISP_BUF` 1→0, next frame's addresses have bit13=1.
- Drop `LCD_EN` mid-line at x=82 → no further pushes of that frame, no `FRAME_DONE`. On re-enable, the first write goes to addr offset 0 in the same buffer.
